// File: rtl/tabla_sweep_ctrl_pkg.sv
// Shared definitions for the truth-table sweep controller: FSM state encoding
// and the vector/counter widths used by the top level.
package tabla_sweep_ctrl_pkg;

    localparam int unsigned VEC_W   = 3;
    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned CNT_W   = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/tabla_settle_timer.sv
// Settle timer: loads SETTLE_CYC-1 and counts down while enabled.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   load_i       reload the counter (takes priority over counting)
//   en_i         count down by one per cycle while nonzero
//   expired_c_o  combinational: counter has reached zero
module tabla_settle_timer #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam int unsigned CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: reload wins, otherwise decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c_o = (cnt_q == '0);

endmodule

// File: rtl/tabla_sweep_ctrl.sv
// Sweeps all eight {A,B,C} vectors into N_IMPL parallel truth-table
// implementations, compares each against the golden table, captures impl 0's
// table, counts failing vectors and records the first failing vector.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start        begin a sweep (honoured in IDLE or DONE only)
//   abort        synchronous return to IDLE, highest priority
//   y_in         implementation outputs, bit i = impl i
//   abc          vector driven to all implementations
//   busy, done   sweep in progress / sweep complete (held)
//   pass         done with zero errors
//   err_cnt      failing-vector count
//   fail_vld     any failure seen; first_fail = first failing vector
//   tt_cap       impl 0 captured table, tt_cap[v] = y_in[0] at vector v
module tabla_sweep_ctrl
    import tabla_sweep_ctrl_pkg::*;
#(
    parameter int unsigned N_IMPL     = 3,
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [7:0]  EXPECTED   = 8'h96
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [N_IMPL-1:0]  y_in,
    output logic [VEC_W-1:0]   abc,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               fail_vld,
    output logic [VEC_W-1:0]   first_fail,
    output logic [NUM_VEC-1:0] tt_cap
);

    state_e               state_q, state_d;
    logic [VEC_W-1:0]     abc_q, abc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic                 fv_q, fv_d;
    logic [VEC_W-1:0]     ff_q, ff_d;
    logic [NUM_VEC-1:0]   tt_q, tt_d;

    logic tmr_load, tmr_en, tmr_expired_c;
    logic mismatch_c;

    tabla_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (tmr_load),
        .en_i        (tmr_en),
        .expired_c_o (tmr_expired_c)
    );

    // Any implementation disagreeing with the golden bit for the current vector.
    assign mismatch_c = |(y_in ^ {N_IMPL{EXPECTED[abc_q]}});

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        abc_d    = abc_q;
        err_d    = err_q;
        fv_d     = fv_q;
        ff_d     = ff_q;
        tt_d     = tt_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    abc_d    = '0;
                    err_d    = '0;
                    fv_d     = 1'b0;
                    ff_d     = '0;
                    tt_d     = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expired_c) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                tt_d[abc_q] = y_in[0];
                if (mismatch_c) begin
                    err_d = err_q + CNT_W'(1);
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        ff_d = abc_q;
                    end
                end
                if (abc_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    abc_d    = abc_q + VEC_W'(1);
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything; results from earlier vectors are kept.
        if (abort) begin
            state_d  = ST_IDLE;
            abc_d    = '0;
            err_d    = err_q;
            fv_d     = fv_q;
            ff_d     = ff_q;
            tt_d     = tt_q;
            tmr_load = 1'b0;
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            tt_q    <= tt_d;
        end
    end

    assign abc        = abc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign fail_vld   = fv_q;
    assign first_fail = ff_q;
    assign tt_cap     = tt_q;

endmodule

// File: tb/tb_tabla_sweep_ctrl.sv
// Directed bench for tabla_sweep_ctrl: XOR3 sweep, mismatching impls, async
// reset mid-sweep, start while busy, abort, and start+abort in DONE.
module tb_tabla_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // DUT a: golden 8'h96, all impls XOR3 (impl1 optionally corrupted)
    logic       start_a = 1'b0, abort_a = 1'b0, inj = 1'b0;
    logic [2:0] y_a, abc_a, ff_a;
    logic       busy_a, done_a, pass_a, fv_a;
    logic [3:0] err_a;
    logic [7:0] tt_a;

    // DUT b: golden 8'h86, impl0/impl2 = 8'h86, impl1 = 8'h92
    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [2:0] y_b, abc_b, ff_b;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [3:0] err_b;
    logic [7:0] tt_b;
    logic [7:0] tbl86 = 8'h86;
    logic [7:0] tbl92 = 8'h92;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign y_a = {3{^abc_a}} ^ ((inj && (abc_a < 3'd2)) ? 3'b010 : 3'b000);
    assign y_b = {tbl86[abc_b], tbl92[abc_b], tbl86[abc_b]};

    tabla_sweep_ctrl #(.N_IMPL(3), .SETTLE_CYC(2), .EXPECTED(8'h96)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .y_in(y_a),
        .abc(abc_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .fail_vld(fv_a), .first_fail(ff_a), .tt_cap(tt_a)
    );

    tabla_sweep_ctrl #(.N_IMPL(3), .SETTLE_CYC(2), .EXPECTED(8'h86)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .y_in(y_b),
        .abc(abc_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .fail_vld(fv_b), .first_fail(ff_b), .tt_cap(tt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle start pulse; returns at the negedge after the sampling edge.
    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic check_clean_done(input string tag);
        check_eq({tag, "_done"}, 32'(done_a), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy_a), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass_a), 32'd1);
        check_eq({tag, "_err"},  32'(err_a),  32'd0);
        check_eq({tag, "_fv"},   32'(fv_a),   32'd0);
        check_eq({tag, "_abc"},  32'(abc_a),  32'd7);
        check_eq({tag, "_tt"},   32'(tt_a),   32'h96);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_abc"},  32'(abc_a),  32'd0);
        check_eq({tag, "_busy"}, 32'(busy_a), 32'd0);
        check_eq({tag, "_done"}, 32'(done_a), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass_a), 32'd0);
        check_eq({tag, "_err"},  32'(err_a),  32'd0);
        check_eq({tag, "_fv"},   32'(fv_a),   32'd0);
        check_eq({tag, "_ff"},   32'(ff_a),   32'd0);
        check_eq({tag, "_tt"},   32'(tt_a),   32'd0);
    endtask

    initial begin
        // Reset state
        cycles(2);
        check_all_zero("rst");
        check_eq("rst_b_tt", 32'(tt_b), 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // Test 1: clean XOR3 sweep, each vector held 3 cycles, done at t+24
        pulse_start_a();
        for (int k = 0; k < 24; k++) begin
            check_eq($sformatf("t1_abc_k%0d", k), 32'(abc_a), 32'(k / 3));
            check_eq($sformatf("t1_busy_k%0d", k), 32'(busy_a), 32'd1);
            check_eq($sformatf("t1_done_k%0d", k), 32'(done_a), 32'd0);
            cycles(1);
        end
        check_clean_done("t1");
        cycles(3);
        check_eq("t1_done_held", 32'(done_a), 32'd1);

        // Test 2: impl1 differs from golden at vectors 2 and 4
        start_b = 1'b1;
        cycles(1);
        start_b = 1'b0;
        cycles(23);
        check_eq("t2_done_early", 32'(done_b), 32'd0);
        cycles(1);
        check_eq("t2_done", 32'(done_b), 32'd1);
        check_eq("t2_err",  32'(err_b),  32'd2);
        check_eq("t2_fv",   32'(fv_b),   32'd1);
        check_eq("t2_ff",   32'(ff_b),   32'd2);
        check_eq("t2_pass", 32'(pass_b), 32'd0);
        check_eq("t2_tt",   32'(tt_b),   32'h86);

        // Test 3: async reset while abc=5 in SETTLE, then a clean sweep
        pulse_start_a();
        cycles(15);
        check_eq("t3_abc_pre", 32'(abc_a), 32'd5);
        rst_n = 1'b0;
        #1;
        check_all_zero("t3_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        pulse_start_a();
        cycles(24);
        check_clean_done("t3");

        // Test 4: start pulsed while busy at abc=3 is ignored
        pulse_start_a();
        cycles(9);
        check_eq("t4_abc_pre", 32'(abc_a), 32'd3);
        pulse_start_a();
        cycles(13);
        check_eq("t4_done_early", 32'(done_a), 32'd0);
        check_eq("t4_abc_k23", 32'(abc_a), 32'd7);
        cycles(1);
        check_clean_done("t4");

        // Test 5: abort in SAMPLE at abc=2; vectors 0,1 already failed via impl1
        inj = 1'b1;
        pulse_start_a();
        cycles(8);
        check_eq("t5_abc_pre", 32'(abc_a), 32'd2);
        abort_a = 1'b1;
        cycles(1);
        abort_a = 1'b0;
        check_eq("t5_busy", 32'(busy_a), 32'd0);
        check_eq("t5_done", 32'(done_a), 32'd0);
        check_eq("t5_abc",  32'(abc_a),  32'd0);
        check_eq("t5_pass", 32'(pass_a), 32'd0);
        check_eq("t5_err",  32'(err_a),  32'd2);
        check_eq("t5_fv",   32'(fv_a),   32'd1);
        check_eq("t5_ff",   32'(ff_a),   32'd0);
        check_eq("t5_tt",   32'(tt_a & 8'hFB), 32'h02);
        cycles(2);
        check_eq("t5_idle", 32'(busy_a), 32'd0);

        // Test 6: failing sweep to DONE, then start+abort together, then start
        pulse_start_a();
        cycles(24);
        check_eq("t6_done", 32'(done_a), 32'd1);
        check_eq("t6_err",  32'(err_a),  32'd2);
        check_eq("t6_pass", 32'(pass_a), 32'd0);
        check_eq("t6_ff",   32'(ff_a),   32'd0);
        start_a = 1'b1;
        abort_a = 1'b1;
        cycles(1);
        start_a = 1'b0;
        abort_a = 1'b0;
        check_eq("t6_ab_done", 32'(done_a), 32'd0);
        check_eq("t6_ab_busy", 32'(busy_a), 32'd0);
        check_eq("t6_ab_abc",  32'(abc_a),  32'd0);
        check_eq("t6_ab_err",  32'(err_a),  32'd2);
        cycles(1);
        check_eq("t6_ab_idle", 32'(busy_a), 32'd0);
        inj = 1'b0;
        pulse_start_a();
        check_eq("t6_rs_busy", 32'(busy_a), 32'd1);
        check_eq("t6_rs_err",  32'(err_a),  32'd0);
        check_eq("t6_rs_fv",   32'(fv_a),   32'd0);
        check_eq("t6_rs_tt",   32'(tt_a),   32'd0);
        check_eq("t6_rs_done", 32'(done_a), 32'd0);
        cycles(24);
        check_clean_done("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
